// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: control-state encodings,
// opcode values and opcode classes.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    INSTRUCTION_FETCH    = 4'd0,
    REGISTER_FETCH       = 4'd1,
    IMMEDIATE_INJECTION3 = 4'd2,
    ALU_R3               = 4'd3,
    ALU_RI3              = 4'd4,
    ALU4                 = 4'd5,
    BRANCH3              = 4'd6,
    MEMORY_REF3          = 4'd7,
    LOAD4                = 4'd8,
    STORE4               = 4'd9,
    LOAD5                = 4'd10,
    JUMP3                = 4'd11,
    HALT                 = 4'd12
  } ctrl_state_e;

  typedef enum logic [2:0] {
    CLS_ALU_R   = 3'd0,
    CLS_ALU_RI  = 3'd1,
    CLS_LDI     = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_MEM     = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_e;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_SLT  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SUBI = 6'h09;
  localparam logic [5:0] OP_ANDI = 6'h0A;
  localparam logic [5:0] OP_ORI  = 6'h0B;
  localparam logic [5:0] OP_LDI  = 6'h10;
  localparam logic [5:0] OP_BEQ  = 6'h14;
  localparam logic [5:0] OP_LD   = 6'h18;
  localparam logic [5:0] OP_STR  = 6'h19;
  localparam logic [5:0] OP_JUMP = 6'h1C;

  // Leaving one of these states for INSTRUCTION_FETCH retires an instruction.
  function automatic logic is_terminal(input ctrl_state_e s);
    return s inside {ALU4, LOAD5, STORE4, BRANCH3, JUMP3, IMMEDIATE_INJECTION3};
  endfunction

  function automatic logic is_mem_wait_state(input ctrl_state_e s);
    return s inside {INSTRUCTION_FETCH, LOAD4, STORE4};
  endfunction

endpackage

// File: rtl/control_sequencer_classifier.sv
// Combinational opcode classifier: maps a 6-bit opcode onto the execution
// path class used by the sequencer in REGISTER_FETCH.
module opcode_classifier
  import control_sequencer_pkg::*;
(
  input  logic [5:0] i_opcode,
  output op_class_e  o_class
);

  // NOTE: every output of an always_comb gets a default first so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    o_class = CLS_ILLEGAL;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: o_class = CLS_ALU_R;
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI:             o_class = CLS_ALU_RI;
      OP_LDI:                                        o_class = CLS_LDI;
      OP_BEQ:                                        o_class = CLS_BRANCH;
      OP_LD, OP_STR:                                 o_class = CLS_MEM;
      OP_JUMP:                                       o_class = CLS_JUMP;
      default:                                       o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle CPU control sequencer with retirement pulse/count and illegal-
// opcode trap. Optional memory handshake stalls: define CONTROL_SEQ_MEMWAIT_EN.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             stall,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  ctrl_state_e      r_state;
  logic [5:0]       r_op_q;
  logic [CNT_W-1:0] r_instr_count;
  logic             r_instr_done;

  ctrl_state_e      w_next_state;
  op_class_e        w_class;
  logic             w_mem_ok;
  logic             w_advance;
  logic             w_latch_op;
  logic             w_retire;

  opcode_classifier u_classifier (
    .i_opcode (opcode),
    .o_class  (w_class)
  );

`ifdef CONTROL_SEQ_MEMWAIT_EN
  assign w_mem_ok = is_mem_wait_state(r_state) ? mem_ready : 1'b1;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_ok           = 1'b1;
`endif

  // Stall outranks the memory wait; either one freezes the whole sequencer.
  assign w_advance = !stall && w_mem_ok;

  always_comb begin
    w_next_state = r_state;
    w_latch_op   = 1'b0;
    w_retire     = 1'b0;
    if (w_advance) begin
      case (r_state)
        INSTRUCTION_FETCH: w_next_state = REGISTER_FETCH;
        REGISTER_FETCH: begin
          w_latch_op = 1'b1;
          case (w_class)
            CLS_ALU_R:  w_next_state = ALU_R3;
            CLS_ALU_RI: w_next_state = ALU_RI3;
            CLS_LDI:    w_next_state = IMMEDIATE_INJECTION3;
            CLS_BRANCH: w_next_state = BRANCH3;
            CLS_MEM:    w_next_state = MEMORY_REF3;
            CLS_JUMP:   w_next_state = JUMP3;
            default:    w_next_state = HALT;
          endcase
        end
        ALU_R3, ALU_RI3: w_next_state = ALU4;
        // The latched opcode decides: the live field may already have moved on.
        MEMORY_REF3:     w_next_state = (r_op_q == OP_LD) ? LOAD4 : STORE4;
        LOAD4:           w_next_state = LOAD5;
        HALT:            w_next_state = HALT;
        default: begin
          w_next_state = INSTRUCTION_FETCH;
          w_retire     = is_terminal(r_state);
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= INSTRUCTION_FETCH;
      r_op_q        <= '0;
      r_instr_count <= '0;
      r_instr_done  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_instr_done <= w_retire;
      if (w_latch_op) r_op_q <= opcode;
      if (w_retire)   r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  // HALT is absorbing until reset, so the trap flag is just the state itself.
  assign state       = r_state;
  assign instr_done  = r_instr_done;
  assign halted      = (r_state == HALT);
  assign instr_count = r_instr_count;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle control state machine for the CPU datapath. It advances the 4-bit control state each clock and selects the next execution path from the instruction opcode. It drives the `state` input of `ControlDecode`, which turns `state` and `opcode` into datapath strobes. It also reports instruction completion, keeps a retired-instruction count, and traps on undefined opcodes.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `opcode`  in  6: opcode field of the instruction register; valid from `REGISTER_FETCH` onward.
- `stall`  in  1: freezes the sequencer for the cycle.
- `mem_ready`  in  1: memory handshake; used only when `CONTROL_SEQ_MEMWAIT_EN` is defined.
- `state`  out  4: current control state, fed to `ControlDecode`.
- `instr_done`  out  1: one-cycle pulse marking one retired instruction.
- `halted`  out  1: set once an undefined opcode reaches `REGISTER_FETCH`; sticky.
- `instr_count`  out  CNT_W: number of retired instructions.

## Operation
- States use `ControlStates.vh` encodings: `INSTRUCTION_FETCH`=0, `REGISTER_FETCH`=1, `IMMEDIATE_INJECTION3`=2, `ALU_R3`=3, `ALU_RI3`=4, `ALU4`=5, `BRANCH3`=6, `MEMORY_REF3`=7, `LOAD4`=8, `STORE4`=9, `LOAD5`=10, `JUMP3`=11, `HALT`=12. Codes 13–15 are unreachable and recover to `INSTRUCTION_FETCH` on the next edge.
- `INSTRUCTION_FETCH` always goes to `REGISTER_FETCH`.
- In `REGISTER_FETCH`, `opcode` is latched into `op_q` and the next state depends on its class:
  - R-type ALU (e.g. `ADD`) → `ALU_R3`
  - immediate ALU (e.g. `ADDI`) → `ALU_RI3`
  - `LDI` → `IMMEDIATE_INJECTION3`
  - `BEQ` → `BRANCH3`
  - `LD` or `STR` → `MEMORY_REF3`
  - `JUMP` → `JUMP3`
  - any other opcode → `HALT`
- `ALU_R3` and `ALU_RI3` go to `ALU4`, then `INSTRUCTION_FETCH`.
- `MEMORY_REF3` goes to `LOAD4` if `op_q`=`LD`, else to `STORE4`. `op_q` is used, not the live `opcode`.
- `LOAD4` goes to `LOAD5`, then `INSTRUCTION_FETCH`.
- `STORE4`, `BRANCH3`, `JUMP3` and `IMMEDIATE_INJECTION3` go to `INSTRUCTION_FETCH`.
- `HALT` is absorbing until reset. `halted` is set on entry to `HALT`.
- A transition from any terminal state to `INSTRUCTION_FETCH` retires one instruction. Terminal states: `ALU4`, `LOAD5`, `STORE4`, `BRANCH3`, `JUMP3`, `IMMEDIATE_INJECTION3`.
- On that same edge, `instr_done` is registered to 1 and `instr_count` increments. `instr_count` wraps from 2^CNT_W−1 to 0.
- Priority: reset > `stall` > memory wait > normal transition.
- While `stall`=1, `state`, `op_q` and `instr_count` hold, and `instr_done` is 0.

## Timing
- Reset values: `state`=`INSTRUCTION_FETCH`, `instr_done`=0, `halted`=0, `instr_count`=0, `op_q`=0.
- Reset is asynchronous. Asserting it mid-instruction aborts that instruction; it is not counted.
- Cycles per instruction with no stall or wait: `LDI` 3, `BEQ` 3, `JUMP` 3, ALU R/RI 4, `STR` 4, `LD` 5.
- `instr_done` is high exactly during the first `INSTRUCTION_FETCH` cycle after a retirement. It is never high after reset or after a stalled cycle.
- `opcode` is sampled only on the `REGISTER_FETCH` edge. Changes at any other time have no effect.
- Stall on the retiring edge: both the retirement and the pulse are deferred to the first unstalled edge.

## Configuration
- `CONTROL_SEQ_MEMWAIT_EN` defined:
  - `INSTRUCTION_FETCH`, `LOAD4` and `STORE4` hold while `mem_ready`=0.
  - Each advances on the first edge where `mem_ready`=1.
  - A retirement from `STORE4` waits for `mem_ready` the same way.
- Not defined: `mem_ready` is ignored, and all states advance every unstalled cycle.

## Structure
- `ControlStates.vh` holds all state encodings, including the new `HALT`=12.
- `opcodes.vh` holds the opcode values and the opcode-class constants.
- One combinational sub-module, `opcode_classifier`, maps the 6-bit opcode to a 3-bit class (ALU_R, ALU_RI, LDI, BRANCH, MEM, JUMP, ILLEGAL).
- The sequencer holds only the state register, `op_q`, the counter and the pulse flop.

## Test plan
- Reset, then `ADD` held, no stall → `state` sequence 0,1,3,5,0. `instr_done`=1 in the final 0 cycle only; `instr_count`=1.
- `LD`, then `opcode` changed to `STR` during `MEMORY_REF3` → path 0,1,7,8,10,0, still taken as the load because `op_q`=`LD`. After a following `STR`: path 0,1,7,9,0 and `instr_count`=2.
- `BEQ`, `JUMP`, `LDI` back-to-back → retirements 3 cycles apart; `instr_count`=3.
- Undefined opcode (e.g. 6'h3F) at `REGISTER_FETCH` → `state`=12 and `halted`=1 on the next edge, held 20 cycles. `reset_n` low then high → `state`=0, `halted`=0.
- `stall`=1 for 3 cycles while in `ALU4` → state holds at 5 and `instr_done` stays 0. Then the next edge goes to 0 with `instr_done`=1.
- With `CONTROL_SEQ_MEMWAIT_EN` and `mem_ready`=0 for 4 cycles in `LOAD4` → state holds at 8, then goes to 10 when `mem_ready`=1. With `CNT_W`=2, four retirements wrap `instr_count` to 0.
